// File: rtl/eq_tap_sweep_ctrl.sv
// eq_tap_sweep_ctrl: sweeps the TX FFE/de-emphasis tap code from TAP_MIN to
// TAP_MAX in TAP_STEP increments. For each code it drops DISCARD_WINDOWS
// eye-monitor windows, then scores the next window. It finishes by applying
// the code with the largest opening. Ties keep the lower code.
// Optional feature macro: EQ_SWEEP_AVG2_EN. When it is defined, each score
// is the mean of two consecutive windows.
module eq_tap_sweep_ctrl #(
  parameter int TAP_WIDTH       = 4,
  parameter int TAP_MIN         = 0,
  parameter int TAP_MAX         = 15,
  parameter int TAP_STEP        = 1,
  parameter int DISCARD_WINDOWS = 1,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  real                  opening,
  input  logic                 opening_ready,
  output logic [TAP_WIDTH-1:0] tap_code,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [TAP_WIDTH-1:0] best_tap,
  output real                  best_opening
);

  localparam int CNT_W  = $clog2(DISCARD_WINDOWS + 2);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, UPDATE, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  discard_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  real               score_reg;
`ifdef EQ_SWEEP_AVG2_EN
  logic              second_reg;
  real               first_opening_reg;
`endif

  logic             timeout_hit;
  logic             timeout_exit;
  logic             last_step;
  logic             better;
  logic [TAP_WIDTH:0] next_code_wide;

  // Derived conditions shared by the next-state logic and the datapath
  always_comb begin
    next_code_wide = {1'b0, tap_code} + (TAP_WIDTH+1)'(TAP_STEP);
    last_step      = next_code_wide > (TAP_WIDTH+1)'(TAP_MAX);
    better         = score_reg > best_opening;
    timeout_hit    = !opening_ready && (wait_cnt_reg >= WAIT_W'(TIMEOUT_CYCLES - 1));
    timeout_exit   = ((state_reg == SETTLE) || (state_reg == MEASURE)) && (state_next == FINISH);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FINISH: begin
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        // Leave as soon as the last straddling window has been dropped
        if (discard_cnt_reg == CNT_W'(DISCARD_WINDOWS))
          state_next = MEASURE;
        else if (opening_ready && (discard_cnt_reg + CNT_W'(1) == CNT_W'(DISCARD_WINDOWS)))
          state_next = MEASURE;
        else if (timeout_hit)
          state_next = FINISH;
      end
      MEASURE: begin
`ifdef EQ_SWEEP_AVG2_EN
        if (opening_ready && second_reg) state_next = UPDATE;
`else
        if (opening_ready)               state_next = UPDATE;
`endif
        else if (timeout_hit)            state_next = FINISH;
      end
      UPDATE: begin
        state_next = last_step ? FINISH : SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sweep datapath: tap stepping, best tracking, status flags, wait counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tap_code          <= TAP_WIDTH'(TAP_MIN);
      best_tap          <= TAP_WIDTH'(TAP_MIN);
      best_opening      <= 0.0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
      discard_cnt_reg   <= '0;
      wait_cnt_reg      <= '0;
      score_reg         <= 0.0;
`ifdef EQ_SWEEP_AVG2_EN
      second_reg        <= 1'b0;
      first_opening_reg <= 0.0;
`endif
    end else begin
      // Wait counter restarts on every window and every state change
      if (opening_ready || (state_next != state_reg))
        wait_cnt_reg <= '0;
      else if ((state_reg == SETTLE) || (state_reg == MEASURE))
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);

      if (timeout_exit) begin
        tap_code    <= best_tap;
        busy        <= 1'b0;
        done        <= 1'b1;
        timeout_err <= 1'b1;
      end else begin
        case (state_reg)
          IDLE, FINISH: begin
            if (start) begin
              tap_code        <= TAP_WIDTH'(TAP_MIN);
              best_tap        <= TAP_WIDTH'(TAP_MIN);
              best_opening    <= -1.0e30;
              discard_cnt_reg <= '0;
              busy            <= 1'b1;
              done            <= 1'b0;
              timeout_err     <= 1'b0;
`ifdef EQ_SWEEP_AVG2_EN
              second_reg      <= 1'b0;
`endif
            end
          end
          SETTLE: begin
            if (opening_ready && (discard_cnt_reg != CNT_W'(DISCARD_WINDOWS)))
              discard_cnt_reg <= discard_cnt_reg + CNT_W'(1);
          end
          MEASURE: begin
            if (opening_ready) begin
`ifdef EQ_SWEEP_AVG2_EN
              if (second_reg) begin
                score_reg  <= (first_opening_reg + opening) / 2.0;
                second_reg <= 1'b0;
              end else begin
                first_opening_reg <= opening;
                second_reg        <= 1'b1;
              end
`else
              score_reg <= opening;
`endif
            end
          end
          UPDATE: begin
            if (better) begin
              best_opening <= score_reg;
              best_tap     <= tap_code;
            end
            if (last_step) begin
              // Apply the winner, including a winner found in this very cycle
              tap_code <= better ? tap_code : best_tap;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              tap_code        <= next_code_wide[TAP_WIDTH-1:0];
              discard_cnt_reg <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
